// File: rtl/xgmii_rx_measure_check.sv
// XGMII receive checker for generated IPv4/UDP test frames.
// Validates the test header, measures latency and publishes per-second stats.
module xgmii_rx_measure_check #(
    parameter logic [39:0] MAGIC_CODE = 40'h0,
    parameter logic [15:0] UDP_PORT   = 16'h0d5e
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    input  logic        sec_oneshot,
    input  logic [31:0] global_counter,
    output logic [31:0] rx_pps,
    output logic [31:0] rx_throughput,
    output logic [23:0] rx_latency,
    output logic [23:0] rx_latency_min,
    output logic [23:0] rx_latency_max,
    output logic [31:0] rx_ipv4_ip,
    output logic [31:0] rx_err_count
);

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    state_t state_q, state_d;

    logic [2:0]  wcnt_q, wcnt_d;
    logic [15:0] bytes_q, bytes_d;
    logic [31:0] dstip_q, dstip_d;
    logic [15:0] sport_q, sport_d;
    logic [15:0] dport_q, dport_d;
    logic [39:0] magic_q, magic_d;
    logic [23:0] ts_q, ts_d;

    logic [31:0] acc_pps_q, acc_pps_d;
    logic [31:0] acc_bytes_q, acc_bytes_d;
    logic [23:0] acc_min_q, acc_min_d;
    logic [23:0] acc_max_q, acc_max_d;

    logic [31:0] rx_pps_q, rx_pps_d;
    logic [31:0] rx_thr_q, rx_thr_d;
    logic [23:0] rx_lat_q, rx_lat_d;
    logic [23:0] rx_min_q, rx_min_d;
    logic [23:0] rx_max_q, rx_max_d;
    logic [31:0] rx_ip_q, rx_ip_d;
    logic [31:0] rx_err_q, rx_err_d;

    logic        ctl_any;
    logic [2:0]  ctl_lane;
    logic [7:0]  ctl_byte;
    logic        start0, start4, is_term;
    logic        data_word, frame_err, frame_end, frame_ok;
    logic [15:0] frame_bytes;
    logic [23:0] lat;
    logic [31:0] nx_pps, nx_bytes;
    logic [23:0] nx_min, nx_max;
    logic        unused_gc;

    assign unused_gc = ^global_counter[31:24];

    // Lowest-numbered control lane decides how the word is classified
    always_comb begin
        ctl_any  = 1'b0;
        ctl_lane = 3'd0;
        ctl_byte = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (xgmii_rxc[i]) begin
                ctl_any  = 1'b1;
                ctl_lane = 3'(i);
                ctl_byte = xgmii_rxd[8*i +: 8];
            end
        end
    end

    assign start0  = xgmii_rxc[0] && (xgmii_rxd[7:0] == 8'hfb);
    assign start4  = xgmii_rxc[4] && (xgmii_rxd[39:32] == 8'hfb);
    assign is_term = ctl_any && (ctl_byte == 8'hfd);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start0) state_d = HDR;
            HDR: begin
                if (start0)               state_d = HDR;
                else if (ctl_any)         state_d = IDLE;
                else if (wcnt_q == 3'd7)  state_d = BODY;
            end
            BODY: begin
                if (start0)       state_d = HDR;
                else if (ctl_any) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_word = (state_q != IDLE) && !ctl_any;
        frame_end = (state_q == BODY) && !start0 && is_term;
        frame_err = (state_q == IDLE) ? (!start0 && start4)
                                      : (ctl_any && !frame_end);
        frame_ok  = frame_end && (sport_q == UDP_PORT)
                    && (dport_q == UDP_PORT) && (magic_q == MAGIC_CODE);
        frame_bytes = bytes_q + {13'b0, ctl_lane};
        lat         = global_counter[23:0] - ts_q;

        wcnt_d  = wcnt_q;
        bytes_d = bytes_q;
        dstip_d = dstip_q;
        sport_d = sport_q;
        dport_d = dport_q;
        magic_d = magic_q;
        ts_d    = ts_q;
        if (start0) begin
            wcnt_d  = 3'd1;
            bytes_d = 16'd0;
        end else if (data_word) begin
            bytes_d = bytes_q + 16'd8;
            if (state_q == HDR) begin
                wcnt_d = wcnt_q + 3'd1;
                unique case (wcnt_q)
                    3'd4: dstip_d[31:16] = {xgmii_rxd[55:48], xgmii_rxd[63:56]};
                    3'd5: begin
                        dstip_d[15:0] = {xgmii_rxd[7:0], xgmii_rxd[15:8]};
                        sport_d = {xgmii_rxd[23:16], xgmii_rxd[31:24]};
                        dport_d = {xgmii_rxd[39:32], xgmii_rxd[47:40]};
                    end
                    3'd6: magic_d = {xgmii_rxd[23:16], xgmii_rxd[31:24],
                                     xgmii_rxd[39:32], xgmii_rxd[47:40],
                                     xgmii_rxd[55:48]};
                    3'd7: ts_d = {xgmii_rxd[7:0], xgmii_rxd[15:8],
                                  xgmii_rxd[23:16]};
                    default: ;
                endcase
            end
        end
    end

    // Window values including this cycle's frame, so a frame ending on the
    // second tick lands in the window being published
    always_comb begin
        nx_pps   = acc_pps_q;
        nx_bytes = acc_bytes_q;
        nx_min   = acc_min_q;
        nx_max   = acc_max_q;
        rx_lat_d = rx_lat_q;
        rx_ip_d  = rx_ip_q;
        if (frame_ok) begin
            nx_pps   = acc_pps_q + 32'd1;
            nx_bytes = acc_bytes_q + {16'b0, frame_bytes};
            if (lat < acc_min_q) nx_min = lat;
            if (lat > acc_max_q) nx_max = lat;
            rx_lat_d = lat;
            rx_ip_d  = dstip_q;
        end

        acc_pps_d   = nx_pps;
        acc_bytes_d = nx_bytes;
        acc_min_d   = nx_min;
        acc_max_d   = nx_max;
        rx_pps_d    = rx_pps_q;
        rx_thr_d    = rx_thr_q;
        rx_min_d    = rx_min_q;
        rx_max_d    = rx_max_q;
        if (sec_oneshot) begin
            rx_pps_d    = nx_pps;
            rx_thr_d    = nx_bytes;
            rx_min_d    = nx_min;
            rx_max_d    = nx_max;
            acc_pps_d   = 32'd0;
            acc_bytes_d = 32'd0;
            acc_min_d   = 24'hFFFFFF;
            acc_max_d   = 24'd0;
        end

        rx_err_d = rx_err_q;
        if (frame_err && (rx_err_q != 32'hFFFFFFFF)) rx_err_d = rx_err_q + 32'd1;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wcnt_q      <= 3'd0;
            bytes_q     <= 16'd0;
            dstip_q     <= 32'd0;
            sport_q     <= 16'd0;
            dport_q     <= 16'd0;
            magic_q     <= 40'd0;
            ts_q        <= 24'd0;
            acc_pps_q   <= 32'd0;
            acc_bytes_q <= 32'd0;
            acc_min_q   <= 24'hFFFFFF;
            acc_max_q   <= 24'd0;
            rx_pps_q    <= 32'd0;
            rx_thr_q    <= 32'd0;
            rx_lat_q    <= 24'd0;
            rx_min_q    <= 24'hFFFFFF;
            rx_max_q    <= 24'd0;
            rx_ip_q     <= 32'd0;
            rx_err_q    <= 32'd0;
        end else begin
            wcnt_q      <= wcnt_d;
            bytes_q     <= bytes_d;
            dstip_q     <= dstip_d;
            sport_q     <= sport_d;
            dport_q     <= dport_d;
            magic_q     <= magic_d;
            ts_q        <= ts_d;
            acc_pps_q   <= acc_pps_d;
            acc_bytes_q <= acc_bytes_d;
            acc_min_q   <= acc_min_d;
            acc_max_q   <= acc_max_d;
            rx_pps_q    <= rx_pps_d;
            rx_thr_q    <= rx_thr_d;
            rx_lat_q    <= rx_lat_d;
            rx_min_q    <= rx_min_d;
            rx_max_q    <= rx_max_d;
            rx_ip_q     <= rx_ip_d;
            rx_err_q    <= rx_err_d;
        end
    end

    assign rx_pps         = rx_pps_q;
    assign rx_throughput  = rx_thr_q;
    assign rx_latency     = rx_lat_q;
    assign rx_latency_min = rx_min_q;
    assign rx_latency_max = rx_max_q;
    assign rx_ipv4_ip     = rx_ip_q;
    assign rx_err_count   = rx_err_q;

endmodule

// File: tb/tb_xgmii_rx_measure_check.sv
// Bench for xgmii_rx_measure_check: byte-level frame builder and a
// per-second statistics model driven by random and directed frames.
module tb_xgmii_rx_measure_check;

    localparam logic [39:0] MAGIC = 40'hA55A1234C3;
    localparam logic [15:0] PORT  = 16'h0d5e;
    localparam logic [63:0] IDLEW = 64'h0707070707070707;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [63:0] rxd;
    logic [7:0]  rxc;
    logic        sec;
    logic [31:0] global_counter;
    logic [31:0] rx_pps, rx_throughput, rx_ipv4_ip, rx_err_count;
    logic [23:0] rx_latency, rx_latency_min, rx_latency_max;

    xgmii_rx_measure_check #(.MAGIC_CODE(MAGIC), .UDP_PORT(PORT)) dut (
        .sys_clk(clk), .sys_rst(sys_rst),
        .xgmii_rxd(rxd), .xgmii_rxc(rxc),
        .sec_oneshot(sec), .global_counter(global_counter),
        .rx_pps(rx_pps), .rx_throughput(rx_throughput),
        .rx_latency(rx_latency), .rx_latency_min(rx_latency_min),
        .rx_latency_max(rx_latency_max), .rx_ipv4_ip(rx_ipv4_ip),
        .rx_err_count(rx_err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] gc = 32'd0;

    logic [31:0] m_pps, m_thr, m_ip, m_err, w_pps, w_thr;
    logic [23:0] m_lat, m_min, m_max, w_min, w_max;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pps = 0; m_thr = 0; m_ip = 0; m_err = 0; m_lat = 0;
        m_min = 24'hFFFFFF; m_max = 0;
        w_pps = 0; w_thr = 0; w_min = 24'hFFFFFF; w_max = 0;
    endtask

    task automatic m_valid(input logic [23:0] l, input logic [31:0] ip, input logic [31:0] nb);
        m_lat = l; m_ip = ip;
        w_pps++; w_thr += nb;
        if (l < w_min) w_min = l;
        if (l > w_max) w_max = l;
    endtask

    task automatic m_sec();
        m_pps = w_pps; m_thr = w_thr; m_min = w_min; m_max = w_max;
        w_pps = 0; w_thr = 0; w_min = 24'hFFFFFF; w_max = 0;
    endtask

    task automatic m_error();
        if (m_err != 32'hFFFFFFFF) m_err++;
    endtask

    task automatic check_all();
        chk("pps", rx_pps, m_pps);
        chk("thr", rx_throughput, m_thr);
        chk("lat", {8'h0, rx_latency}, {8'h0, m_lat});
        chk("min", {8'h0, rx_latency_min}, {8'h0, m_min});
        chk("max", {8'h0, rx_latency_max}, {8'h0, m_max});
        chk("ip", rx_ipv4_ip, m_ip);
        chk("err", rx_err_count, m_err);
    endtask

    task automatic word(input logic [63:0] d, input logic [7:0] c, input logic s);
        rxd = d; rxc = c; sec = s; global_counter = gc;
        @(posedge clk); #1;
        gc = gc + 32'd1;
        sec = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) word(IDLEW, 8'hFF, 1'b0);
    endtask

    task automatic sec_pulse();
        word(IDLEW, 8'hFF, 1'b1);
        m_sec();
    endtask

    // nd data words sit between the start word and the end word
    task automatic send_frame(input int nd, input int t, input logic [31:0] ip,
                              input logic [15:0] sp, input logic [15:0] dp,
                              input logic [39:0] mg, input logic [23:0] l,
                              input logic se, input int bad_at);
        logic [7:0]  fr [0:255];
        logic [31:0] ge;
        logic [23:0] ts;
        logic [63:0] d;
        logic [7:0]  c;
        int          bl;
        ge = gc + 32'(nd) + 32'd1;
        ts = ge[23:0] - l;
        for (int i = 0; i < 256; i++) fr[i] = 8'($urandom);
        fr[30] = ip[31:24]; fr[31] = ip[23:16]; fr[32] = ip[15:8]; fr[33] = ip[7:0];
        fr[34] = sp[15:8];  fr[35] = sp[7:0];   fr[36] = dp[15:8]; fr[37] = dp[7:0];
        fr[42] = mg[39:32]; fr[43] = mg[31:24]; fr[44] = mg[23:16];
        fr[45] = mg[15:8];  fr[46] = mg[7:0];
        fr[48] = ts[23:16]; fr[49] = ts[15:8];  fr[50] = ts[7:0];
        word(64'hd5555555555555fb, 8'h01, 1'b0);
        for (int w = 1; w <= nd; w++) begin
            for (int k = 0; k < 8; k++) d[8*k +: 8] = fr[(w-1)*8 + k];
            c = 8'h00;
            if (w == bad_at) begin
                bl = $urandom_range(0, 7);
                d[8*bl +: 8] = 8'h9c;
                c[bl] = 1'b1;
            end
            word(d, c, 1'b0);
            if (w == bad_at) begin
                m_error();
                return;
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (k < t) begin
                d[8*k +: 8] = fr[nd*8 + k]; c[k] = 1'b0;
            end else if (k == t) begin
                d[8*k +: 8] = 8'hfd; c[k] = 1'b1;
            end else begin
                d[8*k +: 8] = 8'h07; c[k] = 1'b1;
            end
        end
        word(d, c, se);
        if (nd < 7) m_error();
        else if (sp == PORT && dp == PORT && mg == MAGIC) m_valid(l, ip, 32'(nd*8 + t));
        if (se) m_sec();
    endtask

    task automatic restart_pre(input int n);
        word(64'hd5555555555555fb, 8'h01, 1'b0);
        for (int i = 0; i < n; i++) word({$urandom, $urandom}, 8'h00, 1'b0);
        m_error();
    endtask

    task automatic lane4_start();
        word(64'h555555fb07070707, 8'h1F, 1'b0);
        word({$urandom, $urandom}, 8'h00, 1'b0);
        word(64'h07070707070707fd, 8'hFF, 1'b0);
        m_error();
    endtask

    initial begin
        int r, nd;
        logic [31:0] ip;
        sys_rst = 1'b1; rxd = IDLEW; rxc = 8'hFF; sec = 1'b0; global_counter = 0;
        m_reset();
        idle(3);
        sys_rst = 1'b0;
        idle(1);
        check_all();

        gc = 32'h180 - 32'd9;
        send_frame(8, 4, 32'hC0A80A05, PORT, PORT, MAGIC, 24'h80, 1'b0, 0);
        idle(1);
        sec_pulse();
        check_all();
        chk("t1_lat", {8'h0, rx_latency}, 32'h80);
        chk("t1_pps", rx_pps, 32'd1);
        chk("t1_thr", rx_throughput, 32'd68);
        chk("t1_ip", rx_ipv4_ip, 32'hC0A80A05);

        gc = 32'h10 - 32'd9;
        send_frame(8, 4, 32'h0A000001, PORT, PORT, MAGIC, 24'h20, 1'b0, 0);
        idle(1);
        chk("wrap_lat", {8'h0, rx_latency}, 32'h20);
        sec_pulse();

        for (int i = 0; i < 1000; i++)
            send_frame(8, 4, 32'h0A000002, PORT, PORT, MAGIC, 24'(10 + i), 1'b0, 0);
        idle(1);
        sec_pulse();
        check_all();
        chk("bb_pps", rx_pps, 32'd1000);
        chk("bb_min", {8'h0, rx_latency_min}, 32'd10);
        chk("bb_max", {8'h0, rx_latency_max}, 32'd1009);
        chk("bb_thr", rx_throughput, 32'd68000);

        send_frame(4, 3, 32'h1, PORT, PORT, MAGIC, 24'h5, 1'b0, 0);
        idle(1);
        chk("runt_err", rx_err_count, 32'd1);
        lane4_start();
        idle(1);
        chk("l4_err", rx_err_count, 32'd2);

        send_frame(9, 2, 32'h2, PORT, PORT, MAGIC ^ 40'h1, 24'h7, 1'b0, 0);
        idle(1);
        send_frame(9, 6, 32'h3, PORT, PORT, MAGIC, 24'h33, 1'b1, 0);
        idle(1);
        check_all();
        chk("coin_pps", rx_pps, 32'd1);
        sec_pulse();
        check_all();
        chk("empty_min", {8'h0, rx_latency_min}, 32'hFFFFFF);

        restart_pre(3);
        send_frame(10, 1, 32'h4, PORT, PORT, MAGIC, 24'h44, 1'b0, 0);
        idle(1);
        check_all();

        for (int it = 0; it < 300; it++) begin
            r  = $urandom_range(0, 9);
            ip = $urandom;
            nd = $urandom_range(7, 14);
            if (r <= 5)
                send_frame(nd, $urandom_range(0, 7), ip,
                           ($urandom_range(0, 9) == 0) ? PORT ^ 16'h1 : PORT,
                           ($urandom_range(0, 9) == 0) ? PORT ^ 16'h100 : PORT,
                           ($urandom_range(0, 4) == 0) ? MAGIC ^ (40'h1 << $urandom_range(0, 39)) : MAGIC,
                           24'($urandom), ($urandom_range(0, 15) == 0), 0);
            else if (r == 6)
                send_frame($urandom_range(0, 6), $urandom_range(0, 7), ip, PORT, PORT,
                           MAGIC, 24'($urandom), 1'b0, 0);
            else if (r == 7)
                send_frame(nd, 0, ip, PORT, PORT, MAGIC, 24'($urandom), 1'b0,
                           $urandom_range(1, nd));
            else if (r == 8)
                lane4_start();
            else begin
                restart_pre($urandom_range(0, 12));
                send_frame(nd, $urandom_range(0, 7), ip, PORT, PORT, MAGIC,
                           24'($urandom), 1'b0, 0);
            end
            idle($urandom_range(0, 2));
            chk("r_lat", {8'h0, rx_latency}, {8'h0, m_lat});
            chk("r_ip", rx_ipv4_ip, m_ip);
            chk("r_err", rx_err_count, m_err);
            if (it % 25 == 24) begin
                sec_pulse();
                check_all();
            end
        end

        send_frame(9, 2, 32'h5, PORT, PORT, MAGIC, 24'h9, 1'b0, 0);
        word(64'hd5555555555555fb, 8'h01, 1'b0);
        word({$urandom, $urandom}, 8'h00, 1'b0);
        sys_rst = 1'b1;
        idle(2);
        sys_rst = 1'b0;
        m_reset();
        idle(1);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xgmii_rx_measure_check.md
Name: xgmii_rx_measure_check

Overview:
- Receive-side checker for the 10G measurement path. It consumes the XGMII receive stream of a port that loops back or forwards our generated IPv4/UDP test frames.
- Delineates frames and validates the test-frame header (UDP ports 0x0d5e/0x0d5e, 40-bit magic code).
- Extracts the 24-bit transmit timestamp and computes one-way latency against global_counter.
- Publishes per-second packets, bytes, latency min/max/last and error counts to the PCI user-register block.

Parameters:
- MAGIC_CODE, 40'h0, magic value expected in the payload. Must equal the generator's `MAGIC_CODE.
- UDP_PORT, 16'h0d5e, required UDP source and destination port.

Ports:
- sys_clk  in  1  156.25 MHz XGMII clock
- sys_rst  in  1  synchronous, active-high reset
- xgmii_rxd  in  64  RX data; lane n = bits [8n+7:8n], lane 0 first on the wire
- xgmii_rxc  in  8  RX control flags, one per lane
- sec_oneshot  in  1  one-cycle pulse per second
- global_counter  in  32  free-running cycle counter, shared with the transmitter
- rx_pps  out  32  valid test frames in the last completed second
- rx_throughput  out  32  bytes of valid test frames in the last completed second
- rx_latency  out  24  latency of the most recent valid test frame
- rx_latency_min  out  24  minimum latency in the last completed second
- rx_latency_max  out  24  maximum latency in the last completed second
- rx_ipv4_ip  out  32  IPv4 destination address of the most recent valid test frame
- rx_err_count  out  32  cumulative count of malformed frames; saturates at 32'hFFFFFFFF

Behaviour:
- Reset values:
  - All outputs 0, except rx_latency_min = 24'hFFFFFF.
  - State IDLE.
  - Internal window accumulators cleared; window minimum accumulator = 24'hFFFFFF.
- Start recognition:
  - A start is recognised only when xgmii_rxc[0]=1 and xgmii_rxd[7:0]=8'hfb. That word is the preamble/SFD word (word 0).
  - A 8'hfb byte with its control flag set in lane 4 is an alignment error: rx_err_count +1, the frame is ignored (state stays IDLE).
- State machine:
  - IDLE -> HDR on a valid start.
  - HDR counts words 1..7 and captures fields:
    - word4: dstip[31:16] = {rxd[55:48], rxd[63:56]}
    - word5: dstip[15:0] = {rxd[7:0], rxd[15:8]}; sport = {rxd[23:16], rxd[31:24]}; dport = {rxd[39:32], rxd[47:40]}
    - word6: magic = {rxd[23:16], rxd[31:24], rxd[39:32], rxd[47:40], rxd[55:48]}
    - word7: timestamp = {rxd[7:0], rxd[15:8], rxd[23:16]}
  - HDR -> BODY after word 7.
  - BODY -> IDLE on the first word carrying 8'hfd with its control flag set, in lane t (t = 0..7). That word is the end word.
- Byte count: 8 × (number of words between word 0 and the end word, exclusive) + t. This covers destination MAC through FCS and must fit in 16 bits.
- Error cases. Each increments rx_err_count by 1, updates no statistics and returns to IDLE; a restart is the only exception:
  - Terminate seen in HDR (runt frame).
  - Any control byte other than 8'hfd in a frame data word.
  - A new lane-0 start while in HDR or BODY. This counts one error and the frame restarts immediately (state re-enters HDR).
- Validity and no-match:
  - A frame is valid if it ends cleanly, sport == dport == UDP_PORT and magic == MAGIC_CODE.
  - A clean frame that fails these matches is neither an error nor counted.
- Latency update, one cycle after a valid end word:
  - latency = global_counter[23:0] sampled at the end word − timestamp, modulo 2^24.
  - rx_latency <= latency; rx_ipv4_ip <= dstip.
  - Window: packet count +1, byte count + byte count of the frame, window min/max updated.
- Per-second window:
  - On sec_oneshot, outputs rx_pps, rx_throughput, rx_latency_min and rx_latency_max take the window accumulators.
  - The accumulators then restart. If a valid-frame update coincides with sec_oneshot, that frame is included in the published values and the new window starts empty.
  - Empty window: min publishes 24'hFFFFFF and max publishes 0.
- Accumulators wrap modulo 2^32; rx_err_count saturates.
- Reset mid-frame: everything returns to reset values and the partial frame is discarded.

Test Plan:
- Single generator-format frame (10 words; terminate lane 4 of word 9; magic match; timestamp 24'h000100; global_counter[23:0]=24'h000180 at end word), then sec_oneshot -> rx_latency=0x80, rx_pps=1, rx_throughput=68, min=max=0x80, rx_ipv4_ip = captured destination IP.
- Latency wrap: timestamp 24'hFFFFF0, counter 24'h000010 at end -> rx_latency=24'h000020.
- Back-to-back 1000 valid frames with latencies 10..1009 in one window -> rx_pps=1000, min=10, max=1009, rx_throughput=68000.
- Terminate in word 5 -> rx_err_count=1, rx_pps unchanged. Lane-4 start -> rx_err_count=2.
- Wrong magic byte, otherwise valid -> no count, no error. Valid frame ending in the same cycle as sec_oneshot -> published rx_pps includes it; next window starts at 0.
- Empty window after a populated one -> rx_pps=0, rx_throughput=0, min=24'hFFFFFF, max=0. Assert sys_rst mid-frame -> all outputs back to reset values.
